seq_stage_controller: RTL
=========================

// Module: seq_stage_controller
// PURPOSE
//  Parametrised stage sequencer and PC owner for the sequential Y86-64 CPU.
//  Walks fetch/decode/execute/memory/writeback/PC stages, emits one-hot stage enables, holds RIP.
//  Adds over the previous sequencer: memory ready handshake with timeout, Y86 status codes (AOK/HLT/ADR/INS),
//  and cycle/instruction counters. Sits at CPU top, driving Fetch, Decode_WriteBack, Execution, Memory_Access, memory.
// PARAMETERS
//  PC_WIDTH     64  width of pc and new_pc
//  RESET_PC     0   pc value loaded at reset
//  INIT_DELAY   10  cycles held in S_INIT (register-file reset window), >=1
//  MEM_TIMEOUT  8   max cycles in S_MEM_WAIT before ADR fault, >=1
//  CNT_WIDTH    32  width of cycle_count / instr_count
// PORTS
//  clock        in   1         system clock, all logic on posedge
//  reset        in   1         synchronous, active-low
//  icode        in   4         decoded icode from Fetch
//  instr_valid  in   1         Fetch: icode/ifun legal
//  imem_error   in   1         instruction address out of range
//  dmem_error   in   1         data address out of range
//  mem_ready    in   1         data memory access complete (sampled in S_MEM_WAIT only)
//  new_pc       in   PC_WIDTH  next PC from Update_PC
//  step         in   1         single-step request, raw button level (SEQ_SINGLE_STEP_EN only)
//  pc           out  PC_WIDTH  current RIP
//  reg_reset    out  1         active-high reset for register file, high in S_INIT
//  fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en  out 1 each  one-hot stage enables
//  state        out  4         current state encoding
//  stat         out  2         AOK=0, HLT=1, ADR=2, INS=3
//  halted       out  1         high in S_HALTED
//  cycle_count  out  CNT_WIDTH cycles spent outside S_INIT/S_HALTED, saturating
//  instr_count  out  CNT_WIDTH retired instructions, saturating
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=S_INIT, pc=RESET_PC, stat=AOK, halted=0, counts=0, init/wait counters=0,
//   reg_reset=1, all stage enables 0. Reset mid-instruction aborts it; no pc update, no retirement.
//  Enables are combinational decodes of state: fetch_en=S_FETCH, decode_en=S_DECODE, exec_en=S_EXECUTE,
//   mem_en=S_MEMORY|S_MEM_WAIT, wb_en=S_WRITEBACK, pc_en=S_PC_UPDATE. At most one high.
//  S_INIT: count INIT_DELAY cycles, then -> S_FETCH; reg_reset drops with the transition.
//  S_FETCH: imem_error -> S_HALTED, stat=ADR; else -> S_DECODE.
//  S_DECODE: priority: !instr_valid -> S_HALTED, stat=INS; icode==IHALT -> S_HALTED, stat=HLT; else -> S_EXECUTE.
//  S_EXECUTE -> S_MEMORY.  S_MEMORY -> S_MEM_WAIT, wait counter cleared.
//  S_MEM_WAIT, priority: dmem_error -> S_HALTED, stat=ADR (no writeback); mem_ready -> S_WRITEBACK;
//   else wait counter +1; counter==MEM_TIMEOUT-1 with no ready -> S_HALTED, stat=ADR.
//   Ready on the timeout cycle wins (ready beats timeout).
//  S_WRITEBACK -> S_PC_UPDATE.
//  S_PC_UPDATE: pc<=new_pc (truncated/zero-ext to PC_WIDTH), instr_count+1 (saturating), -> S_PC_WAIT.
//  S_PC_WAIT -> S_FETCH. Minimum latency per non-memory-stalled instruction: 8 cycles (one ready wait).
//  S_HALTED: absorbing until reset; pc, stat, counts frozen; halted=1. HLT does not increment instr_count.
//  cycle_count increments every cycle in any state except S_INIT/S_HALTED; both counters stick at all-ones.
// CONFIGURATION
//  SEQ_SINGLE_STEP_EN defined: S_PC_WAIT -> S_PAUSE instead of S_FETCH. S_PAUSE leaves to S_FETCH one cycle
//   after a rising edge on step (two-flop sync + edge detect); step held high gives one instruction only.
//   cycle_count does not count in S_PAUSE. Reset clears the sync flops.
//  Not defined: no S_PAUSE state, step port unconnected/ignored, free-running sequencing.
// STRUCTURE
//  Shared constants in cpu_definitions.v: state encodings (S_INIT..S_PAUSE), STAT_AOK/HLT/ADR/INS, IHALT.
//  One sub-module: seq_step_sync (2-flop synchronizer + rising-edge pulse), instantiated only under SEQ_SINGLE_STEP_EN.
// TESTING
//  1. Reset low 3 cycles, release, icode=IIRMOVQ valid -> reg_reset high exactly 10 cycles, first fetch_en on cycle 11.
//  2. Two NOPs, mem_ready asserted in 1st S_MEM_WAIT cycle, new_pc=pc+1 -> pc 0->1->2, instr_count=2, 8 cycles each.
//  3. icode=IHALT at pc=0x10 -> S_HALTED, stat=1, halted=1, pc stays 0x10, instr_count unchanged over 20 cycles.
//  4. mem_ready never asserted, MEM_TIMEOUT=8 -> halt after 8 S_MEM_WAIT cycles, stat=2; ready on 8th cycle -> S_WRITEBACK.
//  5. dmem_error and mem_ready same cycle -> stat=2, wb_en never asserted; instr_valid=0 in decode -> stat=3.
//  6. SEQ_SINGLE_STEP_EN: step held high 50 cycles -> exactly one instruction retires; reset in S_EXECUTE -> pc=RESET_PC.

Source files
------------

// File: rtl/seq_stage_controller_pkg.sv
// Shared encodings for the sequential Y86-64 stage sequencer: state codes,
// architectural status codes and the halt icode.
package seq_stage_controller_pkg;

    typedef enum logic [3:0] {
        S_INIT      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_EXECUTE   = 4'd3,
        S_MEMORY    = 4'd4,
        S_MEM_WAIT  = 4'd5,
        S_WRITEBACK = 4'd6,
        S_PC_UPDATE = 4'd7,
        S_PC_WAIT   = 4'd8,
        S_HALTED    = 4'd9,
        S_PAUSE     = 4'd10
    } state_e;

    typedef enum logic [1:0] {
        STAT_AOK = 2'd0,
        STAT_HLT = 2'd1,
        STAT_ADR = 2'd2,
        STAT_INS = 2'd3
    } stat_e;

    localparam logic [3:0] IHALT = 4'h0;

    // Reset window, halt and single-step pause are not program execution time.
    function automatic logic counts_cycle(input state_e s);
        return !((s == S_INIT) || (s == S_HALTED) || (s == S_PAUSE));
    endfunction

endpackage

// File: rtl/seq_step_sync.sv
// Step button synchronizer with rising-edge pulse; only built when
// SEQ_SINGLE_STEP_EN is defined.
`ifdef SEQ_SINGLE_STEP_EN
module seq_step_sync (
    input  logic clock,
    input  logic reset,
    input  logic step_in,
    output logic step_rise
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;
    logic rise_q, rise_d;

    // Next values for the synchronizer chain and edge detector.
    always_comb begin
        sync1_d = step_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        rise_d  = sync2_q & ~prev_q;
    end

    // Synchronizer, edge-history and pulse registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            rise_q  <= rise_d;
        end
    end

    assign step_rise = rise_q;

endmodule
`endif

// File: rtl/seq_stage_controller.sv
// Stage sequencer and RIP owner for the sequential Y86-64 CPU.
// Optional single-step pause state is enabled by defining SEQ_SINGLE_STEP_EN.
module seq_stage_controller
    import seq_stage_controller_pkg::*;
#(
    parameter int unsigned          PC_WIDTH    = 64,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = {PC_WIDTH{1'b0}},
    parameter int unsigned          INIT_DELAY  = 10,
    parameter int unsigned          MEM_TIMEOUT = 8,
    parameter int unsigned          CNT_WIDTH   = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [3:0]           icode,
    input  logic                 instr_valid,
    input  logic                 imem_error,
    input  logic                 dmem_error,
    input  logic                 mem_ready,
    input  logic [PC_WIDTH-1:0]  new_pc,
    input  logic                 step,
    output logic [PC_WIDTH-1:0]  pc,
    output logic                 reg_reset,
    output logic                 fetch_en,
    output logic                 decode_en,
    output logic                 exec_en,
    output logic                 mem_en,
    output logic                 wb_en,
    output logic                 pc_en,
    output logic [3:0]           state,
    output logic [1:0]           stat,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instr_count
);

    localparam int unsigned INIT_W = (INIT_DELAY > 1) ? $clog2(INIT_DELAY) : 1;
    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [INIT_W-1:0]    INIT_LAST = INIT_W'(INIT_DELAY - 1);
    localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

    state_e                state_q, state_d;
    stat_e                 stat_q, stat_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [INIT_W-1:0]     init_cnt_q, init_cnt_d;
    logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic [CNT_WIDTH-1:0]  cycle_count_q, cycle_count_d;
    logic [CNT_WIDTH-1:0]  instr_count_q, instr_count_d;

`ifdef SEQ_SINGLE_STEP_EN
    logic step_pulse_s;

    seq_step_sync u_step_sync (
        .clock     (clock),
        .reset     (reset),
        .step_in   (step),
        .step_rise (step_pulse_s)
    );
`else
    logic unused_step_s;
    assign unused_step_s = step;
`endif

    // Next-state, status, PC and counter logic.
    always_comb begin
        state_d       = state_q;
        stat_d        = stat_q;
        pc_d          = pc_q;
        init_cnt_d    = init_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        cycle_count_d = cycle_count_q;
        instr_count_d = instr_count_q;

        case (state_q)
            S_INIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    state_d = S_FETCH;
                end else begin
                    init_cnt_d = init_cnt_q + INIT_W'(1);
                end
            end
            S_FETCH: begin
                if (imem_error) begin
                    state_d = S_HALTED;
                    stat_d  = STAT_ADR;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!instr_valid) begin
                    state_d = S_HALTED;
                    stat_d  = STAT_INS;
                end else if (icode == IHALT) begin
                    state_d = S_HALTED;
                    stat_d  = STAT_HLT;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: state_d = S_MEMORY;
            S_MEMORY: begin
                state_d    = S_MEM_WAIT;
                wait_cnt_d = {WAIT_W{1'b0}};
            end
            // A ready arriving on the last permitted wait cycle still completes.
            S_MEM_WAIT: begin
                if (dmem_error) begin
                    state_d = S_HALTED;
                    stat_d  = STAT_ADR;
                end else if (mem_ready) begin
                    state_d = S_WRITEBACK;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_HALTED;
                    stat_d  = STAT_ADR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            S_WRITEBACK: state_d = S_PC_UPDATE;
            S_PC_UPDATE: begin
                state_d = S_PC_WAIT;
                pc_d    = new_pc;
                if (instr_count_q != CNT_MAX) begin
                    instr_count_d = instr_count_q + CNT_WIDTH'(1);
                end else begin
                    instr_count_d = instr_count_q;
                end
            end
`ifdef SEQ_SINGLE_STEP_EN
            S_PC_WAIT: state_d = S_PAUSE;
            S_PAUSE: begin
                if (step_pulse_s) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_PAUSE;
                end
            end
`else
            S_PC_WAIT: state_d = S_FETCH;
`endif
            S_HALTED: state_d = S_HALTED;
            default: begin
                state_d = S_HALTED;
                stat_d  = STAT_INS;
            end
        endcase

        if (counts_cycle(state_q) && (cycle_count_q != CNT_MAX)) begin
            cycle_count_d = cycle_count_q + CNT_WIDTH'(1);
        end else begin
            cycle_count_d = cycle_count_q;
        end
    end

    // State, architectural and counter registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= S_INIT;
            stat_q        <= STAT_AOK;
            pc_q          <= RESET_PC;
            init_cnt_q    <= {INIT_W{1'b0}};
            wait_cnt_q    <= {WAIT_W{1'b0}};
            cycle_count_q <= {CNT_WIDTH{1'b0}};
            instr_count_q <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q       <= state_d;
            stat_q        <= stat_d;
            pc_q          <= pc_d;
            init_cnt_q    <= init_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            cycle_count_q <= cycle_count_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign fetch_en    = (state_q == S_FETCH);
    assign decode_en   = (state_q == S_DECODE);
    assign exec_en     = (state_q == S_EXECUTE);
    assign mem_en      = (state_q == S_MEMORY) || (state_q == S_MEM_WAIT);
    assign wb_en       = (state_q == S_WRITEBACK);
    assign pc_en       = (state_q == S_PC_UPDATE);
    assign reg_reset   = (state_q == S_INIT);
    assign halted      = (state_q == S_HALTED);
    assign state       = state_q;
    assign stat        = stat_q;
    assign pc          = pc_q;
    assign cycle_count = cycle_count_q;
    assign instr_count = instr_count_q;

endmodule
